uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter. The transmit-side counterpart of the oversampled UART receiver: it accepts a parallel word with a one-cycle valid strobe and serialises it onto `TX_OUT` as a start bit, the data bits LSB first, an optional parity bit and a stop bit. Each bit lasts a runtime-programmable `prescale` clock cycles, so the receiver and transmitter share one prescale setting.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame.
- `PRESCALE_WIDTH`, 5: width of the `prescale` input.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `P_DATA`  in  DATA_WIDTH  parallel word to send.
- `DATA_VALID`  in  1  request strobe; accepted only while `busy`=0.
- `PAR_EN`  in  1  1 = append a parity bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `prescale`  in  PRESCALE_WIDTH  clock cycles per bit; 0 is treated as 1.
- `TX_OUT`  out  1  serial line, registered; idles high.
- `busy`  out  1  registered; high from frame acceptance until the end of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `TX_OUT`=1 and `busy`=0.
  - `DATA_VALID`=1 at an edge moves the block to START.
  - On that edge, `P_DATA`, `PAR_EN`, `PAR_TYP` and the effective prescale are latched.
- START: `TX_OUT`=0 for P cycles, then DATA.
- DATA:
  - `TX_OUT` = latched data bit `idx`, with `idx` running 0..DATA_WIDTH-1 and each bit held P cycles.
  - After bit DATA_WIDTH-1, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: `TX_OUT` = XOR of the latched data XOR latched `PAR_TYP`, held P cycles; then STOP.
- STOP: `TX_OUT`=1 for P cycles, then IDLE.
- Bit timer:
  - Counter is PRESCALE_WIDTH bits wide and counts 0..P-1.
  - Terminal count advances the state or bit index and reloads the counter to 0.
  - The bit index is $clog2(DATA_WIDTH) bits wide.
- Inputs that change mid-frame have no effect on the frame in flight: `DATA_VALID` while `busy`=1 is ignored and not queued, and `P_DATA`, `PAR_EN`, `PAR_TYP` and `prescale` are all latched.
- Reset (asynchronous, including mid-frame):
  - State goes to IDLE immediately; `TX_OUT`=1, `busy`=0.
  - All counters and latched registers clear to 0.
  - The partial frame is abandoned.

## Timing
- Reset values: `TX_OUT`=1, `busy`=0.
- Acceptance at edge N: `TX_OUT` falls and `busy` rises after edge N. The start bit covers cycles N+1..N+P.
- Frame length F = (2 + DATA_WIDTH + parity) × P cycles, where parity is 1 if enabled, else 0.
- `busy` falls at edge N+F, and `TX_OUT` is already 1 at that point.
- The earliest next acceptance is edge N+F+1. Back-to-back frames therefore have exactly one idle-high clock between the stop bit and the next start bit.
- When P=1, every bit is one cycle wide and the same transitions apply.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: the PARITY state, the parity latches and the XOR tree are built; `PAR_EN` and `PAR_TYP` behave as described above.
  - Undefined: no PARITY state or parity logic is built. `PAR_EN` and `PAR_TYP` remain as ports but are ignored. Every frame is 2+DATA_WIDTH bits, and DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg`:
  - TX state enum.
  - `START_BIT`=1'b0 and `STOP_BIT`=1'b1.
  - Parity-type encodings `PAR_EVEN`=0 and `PAR_ODD`=1.
- One sub-module, `uart_tx_bit_timer`:
  - Holds the latched prescale and the cycle counter.
  - Outputs a one-cycle `bit_done` pulse; takes `start` (load/clear) and `clk`/`rst`.
- The FSM, bit index, data shift register and output register stay in `uart_tx`.

## Test plan
- prescale=8, parity off, P_DATA=0xA5 → `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 8 cycles; `busy` high for 80 cycles.
- prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5 → parity bit 0, frame 88 cycles. With PAR_TYP=1 → parity bit 1.
- `DATA_VALID` pulsed with 0x3C during a frame, and `prescale` changed mid-frame → in-flight frame unchanged, no second frame sent.
- `DATA_VALID` held high continuously with prescale=4 → consecutive frames separated by exactly one idle-high clock.
- `rst` asserted mid-DATA bit 3 → `TX_OUT`=1 and `busy`=0 with no clock edge. After release, a new 0x0F request produces a clean full frame.
- Build without `UART_TX_PARITY_EN`, PAR_EN=1, prescale=0 → no parity bit, 10-cycle frame (P treated as 1).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and parity codes.
package uart_pkg;
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: latches the effective prescale on start and pulses bit_done
// on the last cycle of every bit period.
module uart_tx_bit_timer #(
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_done
);
  logic [PRESCALE_WIDTH-1:0] p_lat;
  logic [PRESCALE_WIDTH-1:0] cnt;

  // Outside a frame the counter free-runs; the FSM ignores bit_done in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_lat <= '0;
      cnt   <= '0;
    end else if (start) begin
      p_lat <= (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
      cnt   <= '0;
    end else if (bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = (cnt == p_lat - 1'b1);
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      busy
);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_e             state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [IDX_W-1:0]      idx;
  logic                  accept, bit_done, shift, last_bit;
  logic                  tx_nxt, busy_nxt;

  assign accept    = (state == TX_IDLE) && DATA_VALID;
  assign shift     = (state == TX_DATA) && bit_done;
  assign last_bit  = (idx == LAST_IDX);
  assign shreg_nxt = accept ? P_DATA : (shift ? (shreg >> 1) : shreg);

  uart_tx_bit_timer #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .prescale (prescale),
    .bit_done (bit_done)
  );

`ifdef UART_TX_PARITY_EN
  logic par_en, par_bit;

  // Parity is folded at acceptance so only one bit needs holding for the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en  <= 1'b0;
      par_bit <= 1'b0;
    end else if (accept) begin
      par_en  <= PAR_EN;
      par_bit <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
    end
  end
`else
  logic unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= TX_IDLE;
      TX_OUT <= STOP_BIT;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      TX_OUT <= tx_nxt;
      busy   <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:   if (DATA_VALID) state_nxt = TX_START;
      TX_START:  if (bit_done) state_nxt = TX_DATA;
`ifdef UART_TX_PARITY_EN
      TX_DATA:   if (bit_done && last_bit) state_nxt = par_en ? TX_PARITY : TX_STOP;
      TX_PARITY: if (bit_done) state_nxt = TX_STOP;
`else
      TX_DATA:   if (bit_done && last_bit) state_nxt = TX_STOP;
`endif
      TX_STOP:   if (bit_done) state_nxt = TX_IDLE;
      default:   state_nxt = TX_IDLE;
    endcase
  end

  // Output register is loaded with the level of the bit that starts on this edge.
  always_comb begin
    tx_nxt   = TX_OUT;
    busy_nxt = busy;
    if ((state_nxt != state) || shift) begin
      case (state_nxt)
        TX_START:  begin tx_nxt = START_BIT; busy_nxt = 1'b1; end
        TX_DATA:   tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
        TX_PARITY: tx_nxt = par_bit;
`endif
        TX_STOP:   tx_nxt = STOP_BIT;
        default:   begin tx_nxt = STOP_BIT; busy_nxt = 1'b0; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      idx   <= '0;
    end else begin
      shreg <= shreg_nxt;
      if (accept)     idx <= '0;
      else if (shift) idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle frame model plus literal frame checks.
// Expectations follow UART_TX_PARITY_EN the same way the design build does.
module tb_uart_tx;
  localparam int DW = 8;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [PW-1:0] prescale = 5'd8;
  logic          TX_OUT, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  // Model: on acceptance expand the frame into one expected line level per cycle.
  bit   q[$];
  logic exp_tx = 1'b1;
  logic exp_busy = 1'b0;
  bit   chk_en = 1'b0;

  always @(posedge clk or negedge rst) begin : model
    int p;
    bit bits[$];
    if (!rst) begin
      q.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end else if (!exp_busy && DATA_VALID) begin
      p = (prescale == 0) ? 1 : int'(prescale);
      bits.delete();
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(P_DATA[i]);
      if (HAS_PAR && PAR_EN) bits.push_back((^P_DATA) ^ PAR_TYP);
      bits.push_back(1'b1);
      q.delete();
      foreach (bits[k]) repeat (p) q.push_back(bits[k]);
      exp_tx   = q.pop_front();
      exp_busy = 1'b1;
    end else if (q.size() > 0) begin
      exp_tx   = q.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (TX_OUT !== exp_tx || busy !== exp_busy) begin
        failures++;
        $display("FAIL model t=%0t tx=%b busy=%b required tx=%b busy=%b",
                 $time, TX_OUT, busy, exp_tx, exp_busy);
      end
    end
  end

  // Line level on every busy cycle of the current frame.
  bit rec[$];
  always @(negedge clk) if (busy === 1'b1) rec.push_back(TX_OUT);

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  // expv bit i is the level of frame bit i (bit 0 = start bit).
  task automatic check_bits(input string name, input int p, input logic [15:0] expv, input int nbits);
    check({name, " busy_len"}, rec.size(), p * nbits);
    if (rec.size() >= p * nbits) begin
      for (int i = 0; i < nbits; i++) begin
        check($sformatf("%s bit%0d first", name, i), int'(rec[i*p]), int'(expv[i]));
        check($sformatf("%s bit%0d last", name, i), int'(rec[i*p+p-1]), int'(expv[i]));
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] ps);
    @(negedge clk);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = ps; DATA_VALID = 1'b1;
    rec.delete();
    @(negedge clk);
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, " finishes"}, int'(n < 3000), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset tx", int'(TX_OUT), 1);
    check("reset busy", int'(busy), 0);
    rst = 1'b1;
    chk_en = 1'b1;

    send(8'hA5, 1'b0, 1'b0, 5'd8);
    wait_idle("A5 nopar");
    check_bits("A5 nopar", 8, 16'b1101001010, 10);

    send(8'hA5, 1'b1, 1'b0, 5'd8);
    wait_idle("A5 even");
`ifdef UART_TX_PARITY_EN
    check_bits("A5 even", 8, 16'b10101001010, 11);
`else
    check_bits("A5 even", 8, 16'b1101001010, 10);
`endif

    send(8'hA5, 1'b1, 1'b1, 5'd8);
    wait_idle("A5 odd");
`ifdef UART_TX_PARITY_EN
    check_bits("A5 odd", 8, 16'b11101001010, 11);
`else
    check_bits("A5 odd", 8, 16'b1101001010, 10);
`endif

    // Mid-frame request and prescale change must not disturb the frame in flight.
    send(8'h5A, 1'b0, 1'b0, 5'd8);
    repeat (20) @(negedge clk);
    P_DATA = 8'h3C; PAR_EN = 1'b1; prescale = 5'd3; DATA_VALID = 1'b1;
    @(negedge clk);
    DATA_VALID = 1'b0;
    wait_idle("midframe");
    check_bits("midframe", 8, 16'b1010110100, 10);
    rec.delete();
    repeat (20) @(negedge clk);
    check("no queued frame", rec.size(), 0);
    check("idle after midframe", int'(busy), 0);

    // Continuous request: one idle-high cycle between frames.
    @(negedge clk);
    P_DATA = 8'hC3; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 5'd4; DATA_VALID = 1'b1;
    rec.delete();
    @(negedge clk);
    wait_idle("b2b 1");
    check("b2b 1 len", rec.size(), 40);
    check("b2b gap tx", int'(TX_OUT), 1);
    rec.delete();
    @(negedge clk);
    check("b2b 2 busy", int'(busy), 1);
    check("b2b 2 start", int'(TX_OUT), 0);
    wait_idle("b2b 2");
    DATA_VALID = 1'b0;
    check("b2b 2 len", rec.size(), 40);
    repeat (3) @(negedge clk);
    check("b2b stopped", int'(busy), 0);

    // Asynchronous reset in the middle of data bit 3 (a 0 bit).
    send(8'h33, 1'b0, 1'b0, 5'd8);
    repeat (35) @(negedge clk);
    check("pre-reset tx", int'(TX_OUT), 0);
    #2 rst = 1'b0;
    #1;
    check("async reset tx", int'(TX_OUT), 1);
    check("async reset busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(8'h0F, 1'b0, 1'b0, 5'd8);
    wait_idle("post reset");
    check_bits("post reset 0F", 8, 16'b1000011110, 10);

    // prescale 0 behaves as 1.
    send(8'h0F, 1'b1, 1'b0, 5'd0);
    wait_idle("p0");
`ifdef UART_TX_PARITY_EN
    check_bits("p0", 1, 16'b10000011110, 11);
`else
    check_bits("p0", 1, 16'b1000011110, 10);
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
